uart_fifo_out_path: RTL and testbench

- Receive-side datapath: UART receiver → CRC-8/error checker → byte FIFO → paced output handshake.
- Serial bytes on rx are checked, CRC-accumulated and queued. Queued bytes are then presented one at a time on out_data to a downstream consumer (for example a parallel-bus transmitter) using an out_start/out_finish handshake.
- Sits between the board UART pin and the output/transfer stage.

---
 rtl/uart_fifo_out_path.sv | 181 ++++++++++++++++++
 tb/tb_uart_fifo_out_path.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_out_path.sv
// UART receive path: 2-flop rx sync, 8N1 receiver (8E1 when UART_PARITY_EN is defined), CRC-8 and error flags,
// a circular byte FIFO, and a sequencer that hands bytes to the consumer over out_start/out_finish.
module uart_fifo_out_path #(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         DEPTH        = 512,
  parameter logic [7:0] EOM_BYTE     = 8'h0D,
  localparam int        CW           = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  output logic          tx,
  input  logic          com_enable,
  input  logic          out_enable,
  input  logic          out_finish,
  output logic [7:0]    out_data,
  output logic          out_start,
  output logic          out_done,
  output logic          com_finish,
  output logic [7:0]    crc,
  output logic [3:0]    error,
  output logic [CW-1:0] fifo_count,
  output logic          fifo_empty,
  output logic          fifo_full
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(CLKS_PER_BIT);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] HALF_CNT = CNTW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA,
`ifdef UART_PARITY_EN
    R_PARITY,
`endif
    R_STOP, R_DELIVER
  } rx_st_e;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_LOAD, S_WAIT} seq_st_e;

  function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  assign tx = 1'b1;

  // rx_sync_q[1] is the synchronised level, rx_sync_q[2] its previous value for edge detection
  logic [2:0] rx_sync_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_sync_q <= 3'b111;
    else        rx_sync_q <= {rx_sync_q[1:0], rx};
  end
  wire rx_s = rx_sync_q[1];
  wire fall = rx_sync_q[2] & ~rx_sync_q[1];

  rx_st_e          rst_q;
  logic [CNTW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic [7:0]      crc_q;
  logic [3:0]      err_q;
  logic            eom_q;

  wire deliver  = (rst_q == R_DELIVER);
  wire is_eom   = (shift_q == EOM_BYTE);
  wire fifo_we  = deliver & ~is_eom & ~fifo_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_q <= R_IDLE; cnt_q <= '0; bit_q <= '0; shift_q <= '0;
      crc_q <= '0; err_q <= '0; eom_q <= 1'b0;
    end else begin
      case (rst_q)
        R_IDLE: if (com_enable && fall) begin rst_q <= R_START; cnt_q <= '0; end
        R_START:
          if (cnt_q == HALF_CNT) begin
            cnt_q <= '0;
            bit_q <= '0;
            if (rx_s) begin err_q[3] <= 1'b1; rst_q <= R_IDLE; end
            else rst_q <= R_DATA;
          end else cnt_q <= cnt_q + 1'b1;
        R_DATA:
          if (cnt_q == FULL_CNT) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
`ifdef UART_PARITY_EN
            if (bit_q == 3'd7) rst_q <= R_PARITY;
`else
            if (bit_q == 3'd7) rst_q <= R_STOP;
`endif
          end else cnt_q <= cnt_q + 1'b1;
`ifdef UART_PARITY_EN
        R_PARITY:
          if (cnt_q == FULL_CNT) begin
            cnt_q <= '0;
            if (^{shift_q, rx_s}) begin err_q[1] <= 1'b1; rst_q <= R_IDLE; end
            else rst_q <= R_STOP;
          end else cnt_q <= cnt_q + 1'b1;
`endif
        R_STOP:
          if (cnt_q == FULL_CNT) begin
            cnt_q <= '0;
            if (!rx_s) begin err_q[0] <= 1'b1; rst_q <= R_IDLE; end
            else rst_q <= R_DELIVER;
          end else cnt_q <= cnt_q + 1'b1;
        R_DELIVER: begin
          if (is_eom)         eom_q    <= 1'b1;
          else if (fifo_full) err_q[2] <= 1'b1;
          else                crc_q    <= crc8_upd(crc_q, shift_q);
          rst_q <= R_IDLE;
        end
        default: rst_q <= R_IDLE;
      endcase
    end
  end

  // FIFO storage is not reset; pointers and count define what is valid
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic [7:0]    rdata_q;
  seq_st_e       seq_q;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));
  wire   fifo_re    = (seq_q == S_READ) & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (fifo_we) mem_q[wptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0; rptr_q <= '0; count_q <= '0; rdata_q <= '0;
    end else begin
      if (fifo_we) wptr_q <= wptr_q + 1'b1;
      if (fifo_re) begin rptr_q <= rptr_q + 1'b1; rdata_q <= mem_q[rptr_q]; end
      case ({fifo_we, fifo_re})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  logic [7:0] out_data_q;
  logic       out_start_q;

  // out_start rises as LOAD completes, so it coincides with the first WAIT cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_q <= S_IDLE; out_data_q <= '0; out_start_q <= 1'b0;
    end else begin
      case (seq_q)
        S_IDLE: begin
          out_start_q <= 1'b0;
          if (out_enable && !fifo_empty) seq_q <= S_READ;
        end
        S_READ: seq_q <= S_LOAD;
        S_LOAD: begin out_data_q <= rdata_q; out_start_q <= 1'b1; seq_q <= S_WAIT; end
        S_WAIT: begin
          out_start_q <= 1'b0;
          if (out_finish) seq_q <= S_IDLE;
        end
        default: seq_q <= S_IDLE;
      endcase
    end
  end

  assign out_data   = out_data_q;
  assign out_start  = out_start_q;
  assign out_done   = (seq_q == S_IDLE) & fifo_empty;
  assign com_finish = eom_q;
  assign crc        = crc_q;
  assign error      = err_q;
  assign fifo_count = count_q;
endmodule

// File: tb/tb_uart_fifo_out_path.sv
// Self-checking bench for uart_fifo_out_path: randomized frames checked against a queue/CRC reference model.
module tb_uart_fifo_out_path;
  localparam int CLKS  = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0, rx = 1'b1, com_enable = 1'b1, out_enable = 1'b0, out_finish = 1'b1;
  logic          tx, out_start, out_done, com_finish, fifo_empty, fifo_full;
  logic [7:0]    out_data, crc;
  logic [3:0]    error;
  logic [CW-1:0] fifo_count;

  uart_fifo_out_path #(.CLKS_PER_BIT(CLKS), .DEPTH(DEPTH), .EOM_BYTE(8'h0D)) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx), .com_enable(com_enable), .out_enable(out_enable),
    .out_finish(out_finish), .out_data(out_data), .out_start(out_start), .out_done(out_done),
    .com_finish(com_finish), .crc(crc), .error(error), .fifo_count(fifo_count),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full));

  int vectors = 0, miscompares = 0;
  int maxcnt;
  logic [7:0] obs[$];
  logic [7:0] m_crc;

  always @(negedge clk) if (reset && out_start === 1'b1) obs.push_back(out_data);

  // CRC-8, poly 0x07, MSB first: long division of the message stream one bit at a time
  function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] d);
    logic [8:0] acc;
    acc = {1'b0, c};
    for (int i = 7; i >= 0; i--) begin
      acc = {acc[7:0], 1'b0} ^ {8'h00, 1'b0};
      if (acc[8] ^ d[i]) acc[7:0] = acc[7:0] ^ 8'h07;
      acc[8] = 1'b0;
    end
    return acc[7:0];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    if (int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
  endtask

  task automatic bit_t(input logic v);
    rx = v;
    repeat (CLKS) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok = 1'b1, input bit par_ok = 1'b1);
    bit_t(1'b0);
    for (int i = 0; i < 8; i++) bit_t(b[i]);
`ifdef UART_PARITY_EN
    bit_t((^b) ^ ~par_ok);
`endif
    bit_t(stop_ok);
    rx = 1'b1;
    repeat (2 * CLKS) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0; rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) tick();
    m_crc = 8'h00; maxcnt = 0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (out_done !== 1'b1 && k < 3000) begin tick(); k++; end
    repeat (3) tick();
    vectors++;
    if (k >= 3000) begin miscompares++; $display("FAIL drain_timeout out_done=%b want 1", out_done); end
  endtask

  task automatic test_reset();
    reset = 1'b0; rx = 1'b1;
    repeat (4) @(posedge clk);
    #1 vectors++;
    if ({out_data, out_start, crc, error, com_finish, fifo_count} !== '0 || fifo_empty !== 1'b1 ||
        out_done !== 1'b1 || tx !== 1'b1 || fifo_full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values data=%h start=%b crc=%h err=%h eom=%b cnt=%0d empty=%b done=%b tx=%b; want zeros, empty/done/tx=1",
               out_data, out_start, crc, error, com_finish, fifo_count, fifo_empty, out_done, tx);
    end
    reset = 1'b1;
    repeat (2) tick();
    vectors++;
    if (tx !== 1'b1 || out_done !== 1'b1) begin
      miscompares++; $display("FAIL reset_release tx=%b done=%b want 1/1", tx, out_done);
    end
    // reset in mid-frame must leave nothing behind
    bit_t(1'b0); bit_t(1'b1); bit_t(1'b0);
    do_reset();
    repeat (12 * CLKS) tick();
    vectors++;
    if (fifo_count !== '0 || error !== 4'h0) begin
      miscompares++; $display("FAIL reset_midframe cnt=%0d err=%h want 0/0", fifo_count, error);
    end
  endtask

  task automatic test_single();
    int base;
    do_reset();
    out_enable = 1'b1; out_finish = 1'b1; base = obs.size();
    send_frame(8'h31);
    wait_idle();
    vectors++;
    if (maxcnt != 1) begin miscompares++; $display("FAIL single_peak_count got %0d want 1", maxcnt); end
    vectors++;
    if (obs.size() - base != 1 || obs[base] !== 8'h31) begin
      miscompares++; $display("FAIL single_data pulses=%0d data=%h want 1/31", obs.size() - base, out_data);
    end
    vectors++;
    if (crc !== 8'h97 || error !== 4'h0 || fifo_count !== '0) begin
      miscompares++; $display("FAIL single_status crc=%h err=%h cnt=%0d want 97/0/0", crc, error, fifo_count);
    end
  endtask

  task automatic test_burst_eom();
    logic [7:0] msg[9];
    int base;
    do_reset();
    out_enable = 1'b0;
    for (int i = 0; i < 9; i++) begin
      msg[i] = 8'h31 + 8'(i);
      send_frame(msg[i]);
      m_crc = ref_crc(m_crc, msg[i]);
    end
    send_frame(8'h0D);
    vectors++;
    if (fifo_count !== CW'(9) || crc !== 8'hF4 || m_crc !== 8'hF4 || com_finish !== 1'b1) begin
      miscompares++;
      $display("FAIL burst_status cnt=%0d crc=%h model=%h eom=%b want 9/F4/F4/1", fifo_count, crc, m_crc, com_finish);
    end
    base = obs.size();
    out_enable = 1'b1;
    wait_idle();
    vectors++;
    if (obs.size() - base != 9) begin
      miscompares++; $display("FAIL burst_pulses got %0d want 9", obs.size() - base);
    end
    for (int i = 0; i < 9 && base + i < obs.size(); i++) begin
      vectors++;
      if (obs[base + i] !== msg[i]) begin
        miscompares++; $display("FAIL burst_byte%0d got %h want %h", i, obs[base + i], msg[i]);
      end
    end
    vectors++;
    if (out_done !== 1'b1 || fifo_empty !== 1'b1) begin
      miscompares++; $display("FAIL burst_done done=%b empty=%b want 1/1", out_done, fifo_empty);
    end
  endtask

  task automatic test_random(input int n);
    logic [7:0] q[$];
    logic [7:0] b;
    int base;
    do_reset();
    out_enable = 1'b0;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == 8'h0D) b = 8'hA5;
      send_frame(b);
      if (q.size() < DEPTH) begin q.push_back(b); m_crc = ref_crc(m_crc, b); end
    end
    vectors++;
    if (int'(fifo_count) != q.size() || crc !== m_crc || fifo_full !== (q.size() == DEPTH) ||
        error !== ((n > DEPTH) ? 4'b0100 : 4'b0000)) begin
      miscompares++;
      $display("FAIL rand%0d_status cnt=%0d want %0d crc=%h want %h full=%b err=%h", n, fifo_count, q.size(),
               crc, m_crc, fifo_full, error);
    end
    base = obs.size();
    out_enable = 1'b1;
    wait_idle();
    vectors++;
    if (obs.size() - base != q.size()) begin
      miscompares++; $display("FAIL rand%0d_pulses got %0d want %0d", n, obs.size() - base, q.size());
    end
    for (int i = 0; i < q.size() && base + i < obs.size(); i++) begin
      vectors++;
      if (obs[base + i] !== q[i]) begin
        miscompares++; $display("FAIL rand%0d_byte%0d got %h want %h", n, i, obs[base + i], q[i]);
      end
    end
  endtask

  task automatic test_errors();
    do_reset();
    out_enable = 1'b0;
    send_frame(8'h55, 1'b0);
    vectors++;
    if (error !== 4'b0001 || fifo_count !== '0) begin
      miscompares++; $display("FAIL stop_low err=%h cnt=%0d want 1/0", error, fifo_count);
    end
    rx = 1'b0; repeat (2) tick(); rx = 1'b1;
    repeat (3 * CLKS) tick();
    vectors++;
    if (error !== 4'b1001 || fifo_count !== '0) begin
      miscompares++; $display("FAIL false_start err=%h cnt=%0d want 9/0", error, fifo_count);
    end
`ifdef UART_PARITY_EN
    send_frame(8'h3C, 1'b1, 1'b0);
    vectors++;
    if (error !== 4'b1011 || fifo_count !== '0) begin
      miscompares++; $display("FAIL parity_bad err=%h cnt=%0d want B/0", error, fifo_count);
    end
`endif
    send_frame(8'h7E);
    vectors++;
    if (fifo_count !== CW'(1) || crc !== ref_crc(8'h00, 8'h7E)) begin
      miscompares++; $display("FAIL recover cnt=%0d crc=%h want 1/%h", fifo_count, crc, ref_crc(8'h00, 8'h7E));
    end
  endtask

  task automatic test_com_enable();
    do_reset();
    out_enable = 1'b0; com_enable = 1'b0;
    send_frame(8'h42);
    vectors++;
    if (fifo_count !== '0 || error !== 4'h0) begin
      miscompares++; $display("FAIL com_disabled cnt=%0d err=%h want 0/0", fifo_count, error);
    end
    com_enable = 1'b1;
  endtask

  task automatic test_handshake();
    logic [7:0] a, b;
    int base;
    bit stable;
    do_reset();
    a = 8'($urandom_range(16, 200)); b = a ^ 8'hFF;
    out_finish = 1'b0; out_enable = 1'b1; base = obs.size();
    send_frame(a);
    send_frame(b);
    vectors++;
    if (obs.size() - base != 1 || out_data !== a || fifo_count !== CW'(1)) begin
      miscompares++; $display("FAIL hs_first pulses=%0d data=%h cnt=%0d want 1/%h/1", obs.size() - base, out_data, fifo_count, a);
    end
    stable = 1'b1;
    repeat (50) begin tick(); if (out_data !== a || fifo_count !== CW'(1)) stable = 1'b0; end
    vectors++;
    if (!stable || obs.size() - base != 1) begin
      miscompares++; $display("FAIL hs_hold data=%h cnt=%0d pulses=%0d want %h/1/1", out_data, fifo_count, obs.size() - base, a);
    end
    // disabling does not abort WAIT, but it parks the sequencer once it returns to IDLE
    out_enable = 1'b0;
    out_finish = 1'b1; tick(); out_finish = 1'b0;
    repeat (20) tick();
    vectors++;
    if (obs.size() - base != 1 || fifo_count !== CW'(1) || out_done !== 1'b0) begin
      miscompares++; $display("FAIL hs_park pulses=%0d cnt=%0d done=%b want 1/1/0", obs.size() - base, fifo_count, out_done);
    end
    out_enable = 1'b1;
    repeat (10) tick();
    vectors++;
    if (obs.size() - base != 2 || out_data !== b || fifo_count !== '0) begin
      miscompares++; $display("FAIL hs_second pulses=%0d data=%h cnt=%0d want 2/%h/0", obs.size() - base, out_data, fifo_count, b);
    end
    out_finish = 1'b1;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_eom();
    test_random($urandom_range(3, DEPTH - 1));
    test_random(DEPTH + 1);
    test_errors();
    test_com_enable();
    test_handshake();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
